// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// FSM state encoding, register offsets and STATUS bit positions.
package mmio_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

  localparam int unsigned ST_BUSY  = 0;
  localparam int unsigned ST_FULL  = 1;
  localparam int unsigned ST_EMPTY = 2;
  localparam int unsigned ST_OVF   = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; power-of-two depth, occupancy counter drives registered full/empty.
// The head entry is presented combinationally on head_c.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_d;
  logic             do_push_c;
  logic             do_pop_c;

  // Full/empty are pre-edge flags, so a push while full is dropped even with a concurrent pop.
  assign do_push_c = push && !full;
  assign do_pop_c  = pop && !empty;

  always_comb begin
    count_d = count;
    if (do_push_c && !do_pop_c) begin
      count_d = count + CW'(1);
    end else if (!do_push_c && do_pop_c) begin
      count_d = count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == CW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= wdata;
  end

  assign head_c = mem[rd_ptr];

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a FIFO, STATUS reports
// busy/full/empty/overflow, and a four-state FSM serialises bytes back to back.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        tx
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [31:0] TXDATA_ADDR = BASE_ADDR + TXDATA_OFS;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + STATUS_OFS;

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_d;
  logic [7:0]       shreg;
  logic [7:0]       shreg_d;
  logic             tx_d;
  logic             overflow;

  logic             hit_tx_c;
  logic             hit_st_c;
  logic             push_c;
  logic             clr_c;
  logic             pop_c;
  logic             bit_end_c;
  logic [7:0]       head_c;
  logic             fifo_full;
  logic             fifo_empty;
  logic             unused_wd;

  assign hit_tx_c  = (a == TXDATA_ADDR);
  assign hit_st_c  = (a == STATUS_ADDR);
  assign sel       = hit_tx_c || hit_st_c;
  assign push_c    = we && hit_tx_c;
  assign clr_c     = we && hit_st_c && wd[ST_OVF];
  assign bit_end_c = (cnt == CNT_LAST);
  assign unused_wd = ^wd[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push_c),
    .wdata  (wd[7:0]),
    .pop    (pop_c),
    .head_c (head_c),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // STATUS read mux; every other address reads zero.
  always_comb begin
    rd = '0;
    if (hit_st_c) begin
      rd[ST_BUSY]  = (state != IDLE);
      rd[ST_FULL]  = fifo_full;
      rd[ST_EMPTY] = fifo_empty;
      rd[ST_OVF]   = overflow;
    end
  end

  // Next-state logic; the baud counter restarts at every state change so each bit is whole.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt + CNT_W'(1);
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    tx_d      = tx;
    pop_c     = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shreg_d = head_c;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end_c) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          tx_d      = shreg[0];
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end_c) begin
          cnt_d = '0;
          if (bit_idx == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            shreg_d   = {1'b0, shreg[7:1]};
            tx_d      = shreg[1];
          end
        end
      end
      STOP: begin
        if (bit_end_c) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            pop_c   = 1'b1;
            shreg_d = head_c;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
      tx      <= 1'b1;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
      tx      <= tx_d;
    end
  end

  // Sticky overflow: set by a push that finds the FIFO full, cleared only by software.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (push_c && fifo_full) begin
      overflow <= 1'b1;
    end else if (clr_c) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed scenarios plus random bus traffic, compared every
// cycle against a frame-position model of the serial line and STATUS register.
module tb_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] STAT = 32'h8000_0004;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        sel;
  logic        tx;

  int checks   = 0;
  int failures = 0;
  int busy_cnt = 0;

  logic [7:0] mq[$];
  logic [7:0] m_cur = 8'd0;
  int         m_pos = -1;
  logic       m_ovf = 1'b0;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd),
    .sel   (sel),
    .tx    (tx)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic e;
    logic f;
    logic b;
    e = (mq.size() == 0);
    f = (mq.size() == DEPTH);
    b = (m_pos >= 0);
    return {28'b0, m_ovf, e, f, b};
  endfunction

  // Line level from position within a 10-bit frame: start, 8 data bits LSB first, stop.
  function automatic logic m_tx();
    int bitn;
    if (m_pos < 0) return 1'b1;
    bitn = m_pos / CPB;
    if (bitn == 0) return 1'b0;
    if (bitn == 9) return 1'b1;
    return m_cur[bitn-1];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pos = -1;
    m_ovf = 1'b0;
  endtask

  task automatic model_edge(input logic we_i, input logic [31:0] a_i, input logic [31:0] wd_i);
    logic pre_full;
    logic do_pop;
    pre_full = (mq.size() == DEPTH);
    do_pop   = (m_pos < 0 || m_pos == FRAME - 1) && (mq.size() != 0);
    if (do_pop) begin
      m_cur = mq.pop_front();
      m_pos = 0;
    end else if (m_pos == FRAME - 1) begin
      m_pos = -1;
    end else if (m_pos >= 0) begin
      m_pos++;
    end
    if (we_i && a_i == BASE) begin
      if (pre_full) m_ovf = 1'b1;
      else mq.push_back(wd_i[7:0]);
    end
    if (we_i && a_i == STAT && wd_i[3]) m_ovf = 1'b0;
  endtask

  task automatic cycle(input logic we_i, input logic [31:0] a_i, input logic [31:0] wd_i);
    logic sel_exp;
    we = we_i;
    a  = a_i;
    wd = wd_i;
    #1;
    sel_exp = (a_i == BASE) || (a_i == STAT);
    check_eq("sel", 32'(sel), 32'(sel_exp));
    check_eq("rd", rd, (a_i == STAT) ? m_status() : 32'h0);
    if (a_i == STAT && rd[0]) busy_cnt++;
    @(posedge clk);
    if (reset) model_edge(we_i, a_i, wd_i);
    else model_reset();
    #1;
    check_eq("tx", 32'(tx), 32'(m_tx()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, STAT, 32'h0);
  endtask

  initial begin
    int r;
    logic [31:0] addr;
    reset = 1'b0;
    we    = 1'b0;
    a     = STAT;
    wd    = 32'h0;
    #12;
    check_eq("reset_tx", 32'(tx), 32'h1);
    check_eq("reset_status", rd, 32'h4);
    check_eq("reset_sel", 32'(sel), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single 0x55 frame; busy must last exactly one frame.
    cycle(1'b1, BASE, 32'hDEAD_BE55);
    busy_cnt = 0;
    idle(FRAME + 5);
    check_eq("busy_55", 32'(busy_cnt), 32'(FRAME));

    // Two bytes on consecutive cycles run back to back.
    cycle(1'b1, BASE, 32'h41);
    cycle(1'b1, BASE, 32'h42);
    busy_cnt = 0;
    idle(2 * FRAME + 5);
    check_eq("busy_4142", 32'(busy_cnt), 32'(2 * FRAME));
    check_eq("empty_after", 32'(rd[2]), 32'h1);

    // Overflow: a ninth byte while one frame is in flight and eight are queued.
    cycle(1'b1, BASE, 32'h11);
    idle(2);
    for (int i = 0; i < 9; i++) cycle(1'b1, BASE, 32'hA0 + 32'(i));
    cycle(1'b0, STAT, 32'h0);
    check_eq("ovf_status", rd, 32'hB);
    cycle(1'b1, STAT, 32'h8);
    check_eq("ovf_clear", 32'(rd[3]), 32'h0);
    idle(9 * FRAME + 10);

    // Unmapped address is ignored.
    cycle(1'b1, 32'h8000_0008, 32'h5A);
    check_eq("bad_addr_rd", rd, 32'h0);
    idle(5);

    // Reset 15 cycles into a frame.
    cycle(1'b1, BASE, 32'hC3);
    cycle(1'b1, BASE, 32'h3C);
    idle(14);
    a = STAT;
    we = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    check_eq("midrst_tx", 32'(tx), 32'h1);
    check_eq("midrst_status", rd, 32'h4);
    idle(3);
    reset = 1'b1;
    idle(2 * FRAME);
    cycle(1'b1, BASE, 32'h96);
    idle(FRAME + 3);

    // Random bus traffic.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 12) begin
        cycle(1'b1, BASE, $urandom());
      end else if (r < 15) begin
        cycle(1'b1, STAT, $urandom());
      end else if (r < 18) begin
        addr = (r == 15) ? 32'h8000_0008 : $urandom();
        cycle(1'b1, addr, $urandom());
      end else if (r < 20) begin
        cycle(1'b0, BASE, $urandom());
      end else begin
        idle(1);
      end
    end
    idle((DEPTH + 1) * FRAME + 10);
    check_eq("drained", rd & 32'h7, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
